// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: sequencing controller for the EX stage and the EX/MEM register.
//   - Detects load-use hazards between ID and EX. It freezes PC and IF/ID for LOAD_STALL cycles
//     and bubbles ID/EX for the same cycles.
//   - Flushes IF/ID, ID/EX and EX/MEM for FLUSH_CYCLES cycles when a branch resolves taken in MEM.
//   - Generates ALU operand forwarding selects. MEM has priority over WB, and r0 is never forwarded.
//   - Keeps saturating debug counters of stall and flush events.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs/id_rt, ex_rs/ex_rt    register fields in ID and EX
//   ex_memread                  EX instruction is a load
//   mem_rd/mem_regwrite         MEM destination and write enable
//   wb_rd/wb_regwrite           WB destination and write enable
//   branch_taken                branch in MEM resolved taken
//   pc_write, ifid_write        front-end load enables
//   idex_bubble                 zero ID/EX control
//   flush_if/flush_id/flush_ex  stage invalidates
//   fwd_a, fwd_b                operand selects: 00 regfile, 10 MEM, 01 WB
//   stall_cnt, flush_cnt        saturating event counters
module ex_hazard_ctrl #(
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             stall_inc, flush_inc;

  localparam logic [3:0] StallRem = 4'(LOAD_STALL - 1);
  localparam logic [3:0] FlushRem = 4'(FLUSH_CYCLES - 1);

  assign hz = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;

    if (reset) begin
      // Outputs stay at RUN defaults while reset is held, whatever state was left behind.
      state_d = StRun;
      rem_d   = 4'd0;
    end else begin
      unique case (state_q)
        StRun, StStall: begin
          if (branch_taken) begin
            // A taken branch wins over a new hazard and aborts a stall in progress.
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = StFlush;
              rem_d   = FlushRem;
            end else begin
              state_d = StRun;
              rem_d   = 4'd0;
            end
          end else if (state_q == StStall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            rem_d       = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_d = StRun;
            end
          end else if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = StStall;
              rem_d   = StallRem;
            end
          end
        end
        StFlush: begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          rem_d    = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  // Counters saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Forwarding is independent of the sequencing state.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      fwd_a = 2'b01;
    end
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rt)) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rt)) begin
      fwd_b = 2'b01;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the EX stage and its EX/MEM register.
- Detects load-use hazards between ID and EX and stalls the front end for a configurable number of bubble cycles.
- Flushes the IF/ID, ID/EX and EX/MEM stages when a branch resolves taken in MEM.
- Generates the ALU operand forwarding selects and keeps saturating stall/flush event counters for debug.

Parameters:
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..15)
FLUSH_CYCLES, 1, cycles flush outputs stay asserted per taken branch (1..15)
CNT_W, 16, width of the stall/flush event counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
ex_rs  in  5  rs field of instruction in EX
ex_rt  in  5  rt field of instruction in EX (instr_2016)
ex_memread  in  1  EX instruction is a load
mem_rd  in  5  destination register in MEM (registered RegDst mux result)
mem_regwrite  in  1  MEM instruction writes the register file
wb_rd  in  5  destination register in WB
wb_regwrite  in  1  WB instruction writes the register file
branch_taken  in  1  branch in MEM resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register load enable
idex_bubble  out  1  zero ctlwb/ctlm into ID/EX
flush_if  out  1  invalidate IF/ID
flush_id  out  1  invalidate ID/EX
flush_ex  out  1  invalidate EX/MEM control (ctlwb_out/ctlm_out)
fwd_a  out  2  ALU operand A select: 00 rdata1, 10 MEM result, 01 WB result
fwd_b  out  2  same for operand B (before ALUSrc mux)
stall_cnt  out  CNT_W  load-use events, saturating
flush_cnt  out  CNT_W  taken-branch events, saturating

Behaviour:
- States: RUN, STALL, FLUSH. Counter rem (4 bits) holds remaining cycles.
- Reset: state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
- Outputs during and immediately after reset: pc_write=1, ifid_write=1, all flush/bubble=0.
- hz = ex_memread && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
- Outputs are combinational from the current state and inputs.
- RUN, branch_taken=1 (priority over hz):
  - Same cycle: flush_if=flush_id=flush_ex=1, pc_write=1, ifid_write=1, idex_bubble=0.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: go to FLUSH with rem=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, hz=1, branch_taken=0:
  - Same cycle: pc_write=0, ifid_write=0, idex_bubble=1.
  - stall_cnt increments.
  - If LOAD_STALL>1: go to STALL with rem=LOAD_STALL-1; otherwise stay in RUN.
- STALL:
  - pc_write=0, ifid_write=0, idex_bubble=1; rem decrements.
  - rem==1 -> RUN next cycle. hz is not re-counted.
  - branch_taken=1 in STALL: abort the stall and apply the RUN branch-flush behaviour this cycle (flush outputs, pc_write=1, flush_cnt++, go to FLUSH or RUN per FLUSH_CYCLES).
- FLUSH:
  - All three flush outputs=1, pc_write=1, ifid_write=1, idex_bubble=0; rem decrements.
  - rem==1 -> RUN next cycle.
  - hz and branch_taken are ignored; no counter updates.
- Forwarding is independent of state:
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs.
  - Else fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs.
  - Else fwd_a=00. fwd_b is the same using ex_rt.
  - MEM always wins over WB. Register 0 is never forwarded.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-STALL or mid-FLUSH: RUN with rem=0 next cycle. No outputs are held over.

Test Plan:
- Reset, then idle inputs -> pc_write=1, ifid_write=1, all flush/bubble=0, fwd_a=fwd_b=00, counters 0.
- LOAD_STALL=1; ex_memread=1, ex_rt=5, id_rs=5 for one cycle -> exactly one cycle with pc_write=0, idex_bubble=1; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- LOAD_STALL=3, hazard pulse -> 3 consecutive stall cycles then RUN. branch_taken in 2nd stall cycle -> stall aborts, flush asserted that cycle, flush_cnt=1.
- FLUSH_CYCLES=2; branch_taken together with hz -> flush for 2 cycles, no stall; stall_cnt=0, flush_cnt=1. A second branch_taken in the FLUSH cycle is not counted.
- mem_rd=wb_rd=7, both regwrite=1, ex_rs=7 -> fwd_a=10. Clear mem_regwrite -> fwd_a=01. Set mem_rd=wb_rd=0 with ex_rs=0 -> fwd_a=00.
- CNT_W=4; 17 separate hazard events -> stall_cnt holds at 15.
